// File: rtl/forward_ctrl.sv
// -----------------------------------------------------------------------------
// forward_ctrl
//
// Forwarding and hazard controller that sits between decode and the operand
// register bank. It follows the destination tags of in-flight instructions
// through the EX, DM and WB stages. From those tags it drives the bank's
// operand-select muxes and its write-address tag. It also raises a one-cycle
// stall when a consumer needs a load result that does not exist yet.
//
// Parameters
//   REG_W     register address width (RA/RB/RW fields)
//   ZERO_REG  when 1, register 0 never matches a tag (never forwarded/stalled)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   issue_valid  in   decode presents a valid instruction this cycle
//   RA, RB       in   source registers of the decoding instruction
//   use_A/use_B  in   instruction actually reads RA / RB
//   RW           in   destination register of the decoding instruction
//   wr_en        in   instruction writes RW
//   is_load      in   instruction is a load (result ready at end of DM)
//   mux_sel_A/B  out  operand select: 00 regfile, 01 ans_ex, 10 ans_dm, 11 ans_wb
//   stall        out  hold fetch/decode this cycle
//   RW_dm        out  destination tag currently in DM
//   wr_en_dm     out  DM-stage instruction writes a register
//   RW_wb        out  destination tag currently in WB
//   wr_en_wb     out  WB-stage instruction writes (regfile write enable)
// -----------------------------------------------------------------------------
module forward_ctrl #(
  parameter int REG_W    = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] RA,
  input  logic [REG_W-1:0] RB,
  input  logic             use_A,
  input  logic             use_B,
  input  logic [REG_W-1:0] RW,
  input  logic             wr_en,
  input  logic             is_load,
  output logic [1:0]       mux_sel_A,
  output logic [1:0]       mux_sel_B,
  output logic             stall,
  output logic [REG_W-1:0] RW_dm,
  output logic             wr_en_dm,
  output logic [REG_W-1:0] RW_wb,
  output logic             wr_en_wb
);

  // Operand source codes, as seen by the register bank's operand muxes.
  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_EX = 2'b01,
    SEL_DM = 2'b10,
    SEL_WB = 2'b11
  } sel_e;

  // ---------------------------------------------------------------------------
  // Stage state
  // The load flag is kept only in EX. Once a load reaches DM its result is
  // forwardable from ans_dm, so later stages never need to know about it.
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] ex_tag_q, ex_tag_d;
  logic             ex_wen_q, ex_wen_d;
  logic             ex_ld_q,  ex_ld_d;
  logic [REG_W-1:0] dm_tag_q, dm_tag_d;
  logic             dm_wen_q, dm_wen_d;
  logic [REG_W-1:0] wb_tag_q, wb_tag_d;
  logic             wb_wen_q, wb_wen_d;

  sel_e sel_a, sel_b;
  logic stall_w;

  // A stage supplies register r when it writes r.
  // With ZERO_REG set, register 0 is hardwired and never matches.
  function automatic logic tag_match(input logic             wen,
                                     input logic [REG_W-1:0] tag,
                                     input logic [REG_W-1:0] r);
    return wen && (tag == r) && !(ZERO_REG && (r == '0));
  endfunction

  // Youngest producer wins. EX holds the most recent instruction, so it is
  // checked first. WB is checked last.
  function automatic sel_e pick_source(input logic             rd_en,
                                       input logic [REG_W-1:0] r);
    sel_e s;
    s = SEL_RF;
    if (rd_en) begin
      if (tag_match(ex_wen_q, ex_tag_q, r))      s = SEL_EX;
      else if (tag_match(dm_wen_q, dm_tag_q, r)) s = SEL_DM;
      else if (tag_match(wb_wen_q, wb_tag_q, r)) s = SEL_WB;
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand selects and load-use stall. This logic is combinational and acts
  // in the same cycle as decode.
  // A load in EX has no result yet, so a dependent consumer must wait one
  // cycle. On the next cycle the load sits in DM and the consumer takes
  // ans_dm. Loads in DM or WB therefore never stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_a   = pick_source(issue_valid && use_A, RA);
    sel_b   = pick_source(issue_valid && use_B, RB);
    stall_w = issue_valid && ex_ld_q &&
              ((use_A && tag_match(ex_wen_q, ex_tag_q, RA)) ||
               (use_B && tag_match(ex_wen_q, ex_tag_q, RB)));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a value before any condition, so no path can leave
    // one unassigned and infer a latch.
    ex_tag_d = RW;
    ex_wen_d = wr_en   && issue_valid;
    ex_ld_d  = is_load && issue_valid;
    dm_tag_d = ex_tag_q;
    dm_wen_d = ex_wen_q;
    wb_tag_d = dm_tag_q;
    wb_wen_d = dm_wen_q;

    // A stalled consumer is replayed next cycle, because decode holds its
    // inputs. Only a bubble enters EX now. The older stages keep draining.
    if (stall_w) begin
      ex_tag_d = '0;
      ex_wen_d = 1'b0;
      ex_ld_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers
  // The reset clears the stages asynchronously. Because every output is derived
  // from this state, the selects, the stall and the write enables all drop as
  // soon as rst rises, even in the middle of a stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag_q <= '0;
      ex_wen_q <= 1'b0;
      ex_ld_q  <= 1'b0;
      dm_tag_q <= '0;
      dm_wen_q <= 1'b0;
      wb_tag_q <= '0;
      wb_wen_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, which is what makes this a shift pipeline.
      ex_tag_q <= ex_tag_d;
      ex_wen_q <= ex_wen_d;
      ex_ld_q  <= ex_ld_d;
      dm_tag_q <= dm_tag_d;
      dm_wen_q <= dm_wen_d;
      wb_tag_q <= wb_tag_d;
      wb_wen_q <= wb_wen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mux_sel_A = sel_a;
  assign mux_sel_B = sel_b;
  assign stall     = stall_w;
  assign RW_dm     = dm_tag_q;
  assign wr_en_dm  = dm_wen_q;
  assign RW_wb     = wb_tag_q;
  assign wr_en_wb  = wb_wen_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_forward_ctrl
//
// Self-checking bench for forward_ctrl. The reference model keeps the
// instructions issued in the last three cycles as a history queue, with the
// youngest first. An operand is forwarded from the youngest older instruction
// that writes it. The select code is that instruction's age (1..3). A stall
// occurs when the most recent instruction is a load that writes a register
// being read.
// -----------------------------------------------------------------------------
module tb_forward_ctrl;

  localparam int REG_W = 5;

  typedef struct {
    logic [REG_W-1:0] dest;
    bit               wen;
    bit               ld;
  } rec_t;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic [REG_W-1:0] RA, RB, RW;
  logic             use_A, use_B, wr_en, is_load;
  logic [1:0]       mux_sel_A, mux_sel_B;
  logic             stall;
  logic [REG_W-1:0] RW_dm, RW_wb;
  logic             wr_en_dm, wr_en_wb;

  int checks = 0;
  int errors = 0;

  rec_t hist[$];      // hist[0] = issued one cycle ago, hist[2] = three ago
  bit   model_stall;

  forward_ctrl #(.REG_W(REG_W), .ZERO_REG(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .RA          (RA),
    .RB          (RB),
    .use_A       (use_A),
    .use_B       (use_B),
    .RW          (RW),
    .wr_en       (wr_en),
    .is_load     (is_load),
    .mux_sel_A   (mux_sel_A),
    .mux_sel_B   (mux_sel_B),
    .stall       (stall),
    .RW_dm       (RW_dm),
    .wr_en_dm    (wr_en_dm),
    .RW_wb       (RW_wb),
    .wr_en_wb    (wr_en_wb)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    rec_t b;
    b.dest = '0; b.wen = 1'b0; b.ld = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(b);
  endtask

  function automatic bit produces(input int age, input logic [REG_W-1:0] r);
    return hist[age].wen && (hist[age].dest == r) && (r != 0);
  endfunction

  // Expected select code: age of the youngest older producer, or 0.
  function automatic logic [1:0] model_sel(input logic rd, input logic [REG_W-1:0] r);
    if (!issue_valid || !rd) return 2'd0;
    for (int a = 0; a < 3; a++)
      if (produces(a, r)) return 2'(a + 1);
    return 2'd0;
  endfunction

  // Compare every DM/WB output and the stall against the model. The selects
  // are compared only when no stall is expected.
  task automatic model_check();
    model_stall = issue_valid && hist[0].ld &&
                  ((use_A && produces(0, RA)) || (use_B && produces(0, RB)));
    check("stall", stall, model_stall);
    if (!model_stall) begin
      check("mux_sel_A", mux_sel_A, model_sel(use_A, RA));
      check("mux_sel_B", mux_sel_B, model_sel(use_B, RB));
    end
    check("wr_en_dm", wr_en_dm, hist[1].wen);
    check("wr_en_wb", wr_en_wb, hist[2].wen);
    if (hist[1].wen) check("RW_dm", RW_dm, hist[1].dest);
    if (hist[2].wen) check("RW_wb", RW_wb, hist[2].dest);
  endtask

  // Drive one decode slot on the falling edge, then check it 1 time unit later.
  task automatic apply(input logic v, input logic [REG_W-1:0] ra, input logic [REG_W-1:0] rb,
                       input logic ua, input logic ub, input logic [REG_W-1:0] rw,
                       input logic we, input logic ld);
    @(negedge clk);
    issue_valid = v; RA = ra; RB = rb; use_A = ua; use_B = ub;
    RW = rw; wr_en = we; is_load = ld;
    #1;
    model_check();
  endtask

  // Advance one rising edge and age the model history.
  task automatic tick();
    rec_t r;
    if (model_stall) begin
      r.dest = '0; r.wen = 1'b0; r.ld = 1'b0;
    end else begin
      r.dest = RW; r.wen = wr_en && issue_valid; r.ld = is_load && issue_valid;
    end
    @(posedge clk);
    hist.push_front(r);
    void'(hist.pop_back());
  endtask

  task automatic bubbles(input int n);
    repeat (n) begin
      apply(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; RA = '0; RB = '0; RW = '0;
    use_A = 1'b0; use_B = 1'b0; wr_en = 1'b0; is_load = 1'b0;
    model_flush();
    model_stall = 1'b0;
    #3;
    check("rst_stall", stall, 1'b0);
    check("rst_wr_en_dm", wr_en_dm, 1'b0);
    check("rst_wr_en_wb", wr_en_wb, 1'b0);
    check("rst_RW_dm", RW_dm, 5'd0);
    check("rst_RW_wb", RW_wb, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // EX forward
    apply(1, 0, 0, 0, 0, 7, 1, 0); tick();
    apply(1, 7, 6, 1, 1, 0, 0, 0);
    check("ex_fwd_A", mux_sel_A, 2'b01);
    check("ex_fwd_B", mux_sel_B, 2'b00);
    tick();

    // DM then WB forward, plus write-tag latency
    bubbles(3);
    apply(1, 0, 0, 0, 0, 5, 1, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0); tick();
    apply(1, 5, 0, 1, 0, 0, 0, 0);
    check("dm_fwd_A", mux_sel_A, 2'b10);
    check("dm_RW_dm", RW_dm, 5'd5);
    check("dm_wr_en_dm", wr_en_dm, 1'b1);
    tick();
    apply(1, 5, 0, 1, 0, 0, 0, 0);
    check("wb_fwd_A", mux_sel_A, 2'b11);
    check("wb_RW_wb", RW_wb, 5'd5);
    check("wb_wr_en_wb", wr_en_wb, 1'b1);
    tick();

    // Priority: youngest producer wins
    bubbles(3);
    repeat (3) begin apply(1, 0, 0, 0, 0, 3, 1, 0); tick(); end
    apply(1, 0, 3, 0, 1, 0, 0, 0);
    check("prio_B", mux_sel_B, 2'b01);
    tick();

    // Load-use: one stall cycle, then DM forward, then a visible bubble
    bubbles(3);
    apply(1, 0, 0, 0, 0, 9, 1, 1); tick();
    apply(1, 9, 0, 1, 0, 10, 1, 0);
    check("lu_stall", stall, 1'b1);
    tick();
    apply(1, 9, 0, 1, 0, 10, 1, 0);
    check("lu_stall_drop", stall, 1'b0);
    check("lu_fwd_A", mux_sel_A, 2'b10);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_bubble_dm", wr_en_dm, 1'b0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_cons_dm", wr_en_dm, 1'b1);
    check("lu_cons_RW_dm", RW_dm, 5'd10);
    tick();

    // Register 0 and immediate operand
    bubbles(3);
    apply(1, 0, 0, 0, 0, 0, 1, 0); tick();
    apply(1, 0, 0, 1, 0, 0, 0, 0);
    check("zero_A", mux_sel_A, 2'b00);
    tick();
    apply(1, 0, 0, 0, 0, 4, 1, 1); tick();
    apply(1, 0, 4, 0, 0, 0, 0, 0);
    check("imm_B", mux_sel_B, 2'b00);
    check("imm_stall", stall, 1'b0);
    tick();

    // Asynchronous reset while a stall is pending and all stages are valid
    apply(1, 0, 0, 0, 0, 2, 1, 0); tick();
    apply(1, 0, 0, 0, 0, 2, 1, 0); tick();
    apply(1, 0, 0, 0, 0, 2, 1, 1); tick();
    apply(1, 2, 2, 1, 1, 0, 0, 0);
    check("pre_rst_stall", stall, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_sel_A", mux_sel_A, 2'b00);
    check("mid_rst_sel_B", mux_sel_B, 2'b00);
    check("mid_rst_wr_en_dm", wr_en_dm, 1'b0);
    check("mid_rst_wr_en_wb", wr_en_wb, 1'b0);
    model_flush();
    #2 rst = 1'b0;
    issue_valid = 1'b0;
    #1;
    model_check();
    tick();

    // Randomised traffic with a small register range to provoke hazards.
    // After a stall, decode inputs are held for the replay.
    for (int i = 0; i < 3000; i++) begin
      if (model_stall) begin
        @(negedge clk);
        #1;
        model_check();
      end else begin
        apply(logic'($urandom_range(0, 7) != 0),
              REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              REG_W'($urandom_range(0, 3)),
              logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
